search_slot_scheduler: RTL and testbench

Task dispatcher and result collector for a barrel-pipelined endgame search core with NCTX interleaved contexts (slots).
- Accepts tasks (board, task id, alpha-beta window) from the host over a valid/ready stream.
- Injects each task into whichever slot the core reports free, tracks per-slot node counts, and aborts a search that exceeds its node budget.
- Returns results over a back-pressured stream; a credit scheme guarantees no result is ever dropped.

---
 rtl/search_slot_scheduler_pkg.sv | 31 +++
 rtl/search_slot_scheduler_if.sv | 56 +++++
 rtl/search_slot_scheduler_fifo.sv | 57 +++++
 rtl/search_slot_scheduler.sv | 159 +++++++++++++++
 tb/tb_search_slot_scheduler.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/search_slot_scheduler_pkg.sv
// Shared widths, score type and the task/result records carried through the scheduler FIFOs.
package search_slot_scheduler_pkg;

   localparam int TASKID_W = 16;
   localparam int NODE_W   = 32;

   typedef logic signed [7:0] score_t;

   localparam score_t SCORE_MIN = -8'sd64;
   localparam score_t SCORE_MAX = 8'sd64;

   typedef struct packed {
      logic [63:0]         player;
      logic [63:0]         opponent;
      logic [TASKID_W-1:0] id;
      score_t              alpha;
      score_t              beta;
   } task_t;

   typedef struct packed {
      logic [TASKID_W-1:0] id;
      score_t              score;
      logic [NODE_W-1:0]   nodes;
      logic                aborted;
   } result_t;

   function automatic logic [NODE_W-1:0] sat_inc(input logic [NODE_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/search_slot_scheduler_if.sv
// Host task stream, core slot handshake and result stream of the slot scheduler.
interface search_slot_scheduler_if #(
   parameter int NCTX = 8
);
   import search_slot_scheduler_pkg::*;

   localparam int SLOT_W = (NCTX > 1) ? $clog2(NCTX) : 1;

   logic                task_valid;
   logic                task_ready;
   logic [63:0]         task_player;
   logic [63:0]         task_opponent;
   logic [TASKID_W-1:0] task_id;
   score_t              task_alpha;
   score_t              task_beta;
   logic [NODE_W-1:0]   node_budget;

   logic [SLOT_W-1:0]   core_slot;
   logic                core_free;
   logic                core_solved;
   score_t              core_res;
   logic                core_move;

   logic                inj_valid;
   logic [63:0]         inj_player;
   logic [63:0]         inj_opponent;
   logic [TASKID_W-1:0] inj_taskid;
   score_t              inj_alpha;
   score_t              inj_beta;
   logic                abort;

   logic                res_valid;
   logic                res_ready;
   logic [TASKID_W-1:0] res_id;
   score_t              res_score;
   logic [NODE_W-1:0]   res_nodes;
   logic                res_aborted;

   logic [NCTX-1:0]     busy_slots;
   logic                err_spurious;

   modport slave (
      input  task_valid, task_player, task_opponent, task_id, task_alpha, task_beta, node_budget,
      input  core_slot, core_free, core_solved, core_res, core_move, res_ready,
      output task_ready, inj_valid, inj_player, inj_opponent, inj_taskid, inj_alpha, inj_beta, abort,
      output res_valid, res_id, res_score, res_nodes, res_aborted, busy_slots, err_spurious
   );

   modport master (
      output task_valid, task_player, task_opponent, task_id, task_alpha, task_beta, node_budget,
      output core_slot, core_free, core_solved, core_res, core_move, res_ready,
      input  task_ready, inj_valid, inj_player, inj_opponent, inj_taskid, inj_alpha, inj_beta, abort,
      input  res_valid, res_id, res_score, res_nodes, res_aborted, busy_slots, err_spurious
   );

endinterface

// File: rtl/search_slot_scheduler_fifo.sv
// Synchronous FIFO with occupancy count; head data is presented combinationally and a push
// becomes visible at the head one cycle later. Push when full and pop when empty are ignored.
module search_slot_scheduler_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_dat,
   output logic [CW-1:0]    o_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push    = i_push & (r_count != CW'(DEPTH));
   assign w_pop     = i_pop & (r_count != '0);
   assign o_pop_dat = r_mem[r_rptr];
   assign o_count   = r_count;

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_push_dat;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/search_slot_scheduler.sv
// Dispatches host tasks into free core slots, enforces per-slot node budgets and collects results;
// a result credit bounds in-flight work so a finished search always has room in the result FIFO.
module search_slot_scheduler
   import search_slot_scheduler_pkg::*;
#(
   parameter int NCTX       = 8,
   parameter int TASK_DEPTH = 16,
   parameter int RES_DEPTH  = 16
) (
   input logic iCLOCK,
   input logic iRESET,
   search_slot_scheduler_if.slave bus
);

   localparam int SLOT_W = (NCTX > 1) ? $clog2(NCTX) : 1;
   localparam int TCW    = $clog2(TASK_DEPTH + 1);
   localparam int RCW    = $clog2(RES_DEPTH + 1);

   task_t               w_task_in;
   task_t               w_task_head;
   result_t             w_res_in;
   result_t             w_res_head;
   logic [TCW-1:0]      w_task_cnt;
   logic [RCW-1:0]      w_res_cnt;
   logic [SLOT_W-1:0]   w_slot;
   logic                w_task_push;
   logic                w_task_full;
   logic                w_task_empty;
   logic                w_inj;
   logic                w_slot_busy;
   logic                w_move;
   logic                w_res_push;
   logic                w_res_pop;
   logic                w_res_vld;
   logic                w_spurious;
   logic [NODE_W-1:0]   w_nodes_nxt;
   logic                w_abort_nxt;

   logic [NCTX-1:0]     r_busy;
   logic [NCTX-1:0]     r_aborted;
   logic [NODE_W-1:0]   r_nodes  [NCTX];
   logic [TASKID_W-1:0] r_taskid [NCTX];
   logic [RCW-1:0]      r_credit;
   logic                r_err;

   assign w_slot       = bus.core_slot;
   assign w_slot_busy  = r_busy[w_slot];
   assign w_task_full  = (w_task_cnt == TCW'(TASK_DEPTH));
   assign w_task_empty = (w_task_cnt == '0);
   assign w_task_push  = bus.task_valid & bus.task_ready;
   assign w_inj        = bus.core_free & ~w_task_empty & (r_credit < RCW'(RES_DEPTH)) & ~iRESET;

   // A move in the same cycle as the solve is counted in the reported result.
   assign w_move      = bus.core_move & w_slot_busy;
   assign w_nodes_nxt = w_move ? sat_inc(r_nodes[w_slot]) : r_nodes[w_slot];
   assign w_abort_nxt = r_aborted[w_slot]
                      | (w_move & (bus.node_budget != '0) & (w_nodes_nxt >= bus.node_budget));

   assign w_res_push = bus.core_solved & w_slot_busy & ~iRESET;
   assign w_spurious = bus.core_solved & ~w_slot_busy;
   assign w_res_vld  = (w_res_cnt != '0) & ~iRESET;
   assign w_res_pop  = w_res_vld & bus.res_ready;

   always_comb begin
      w_task_in          = '0;
      w_task_in.player   = bus.task_player;
      w_task_in.opponent = bus.task_opponent;
      w_task_in.id       = bus.task_id;
      w_task_in.alpha    = bus.task_alpha;
      w_task_in.beta     = bus.task_beta;

      w_res_in         = '0;
      w_res_in.id      = r_taskid[w_slot];
      w_res_in.score   = bus.core_res;
      w_res_in.nodes   = w_nodes_nxt;
      w_res_in.aborted = w_abort_nxt;
   end

   search_slot_scheduler_fifo #(
      .WIDTH ($bits(task_t)),
      .DEPTH (TASK_DEPTH)
   ) u_task_fifo (
      .i_clk      (iCLOCK),
      .i_rst      (iRESET),
      .i_push     (w_task_push),
      .i_push_dat (w_task_in),
      .i_pop      (w_inj),
      .o_pop_dat  (w_task_head),
      .o_count    (w_task_cnt)
   );

   search_slot_scheduler_fifo #(
      .WIDTH ($bits(result_t)),
      .DEPTH (RES_DEPTH)
   ) u_res_fifo (
      .i_clk      (iCLOCK),
      .i_rst      (iRESET),
      .i_push     (w_res_push),
      .i_push_dat (w_res_in),
      .i_pop      (w_res_pop),
      .o_pop_dat  (w_res_head),
      .o_count    (w_res_cnt)
   );

   always_ff @(posedge iCLOCK) begin
      if (iRESET) begin
         r_busy    <= '0;
         r_aborted <= '0;
         r_credit  <= '0;
         r_err     <= 1'b0;
         for (int i = 0; i < NCTX; i++) begin
            r_nodes[i]  <= '0;
            r_taskid[i] <= '0;
         end
      end else begin
         if (w_move) begin
            r_nodes[w_slot]   <= w_nodes_nxt;
            r_aborted[w_slot] <= w_abort_nxt;
         end
         if (w_res_push) begin
            r_busy[w_slot] <= 1'b0;
         end
         // Injection is last so a slot that finishes and is refilled in one cycle stays busy.
         if (w_inj) begin
            r_busy[w_slot]    <= 1'b1;
            r_aborted[w_slot] <= 1'b0;
            r_nodes[w_slot]   <= '0;
            r_taskid[w_slot]  <= w_task_head.id;
         end
         if (w_spurious) begin
            r_err <= 1'b1;
         end
         case ({w_inj, w_res_pop})
            2'b10:   r_credit <= r_credit + 1'b1;
            2'b01:   r_credit <= r_credit - 1'b1;
            default: r_credit <= r_credit;
         endcase
      end
   end

   assign bus.task_ready   = ~w_task_full & ~iRESET;
   assign bus.inj_valid    = w_inj;
   assign bus.inj_player   = w_inj ? w_task_head.player   : '0;
   assign bus.inj_opponent = w_inj ? w_task_head.opponent : '0;
   assign bus.inj_taskid   = w_inj ? w_task_head.id       : '0;
   assign bus.inj_alpha    = w_inj ? w_task_head.alpha    : '0;
   assign bus.inj_beta     = w_inj ? w_task_head.beta     : '0;
   assign bus.abort        = w_slot_busy & r_aborted[w_slot] & ~iRESET;

   assign bus.res_valid    = w_res_vld;
   assign bus.res_id       = w_res_vld ? w_res_head.id      : '0;
   assign bus.res_score    = w_res_vld ? w_res_head.score   : '0;
   assign bus.res_nodes    = w_res_vld ? w_res_head.nodes   : '0;
   assign bus.res_aborted  = w_res_vld ? w_res_head.aborted : 1'b0;

   assign bus.busy_slots   = r_busy;
   assign bus.err_spurious = r_err;

endmodule

// File: tb/tb_search_slot_scheduler.sv
// Directed bench: a RES_DEPTH=16 instance for the main flow and a RES_DEPTH=2 instance for credit limiting.
module tb_search_slot_scheduler;
   import search_slot_scheduler_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   search_slot_scheduler_if #(.NCTX(8)) ifa ();
   search_slot_scheduler_if #(.NCTX(8)) ifb ();

   // The small-credit instance sees exactly the same stimulus.
   assign ifb.task_valid    = ifa.task_valid;
   assign ifb.task_player   = ifa.task_player;
   assign ifb.task_opponent = ifa.task_opponent;
   assign ifb.task_id       = ifa.task_id;
   assign ifb.task_alpha    = ifa.task_alpha;
   assign ifb.task_beta     = ifa.task_beta;
   assign ifb.node_budget   = ifa.node_budget;
   assign ifb.core_slot     = ifa.core_slot;
   assign ifb.core_free     = ifa.core_free;
   assign ifb.core_solved   = ifa.core_solved;
   assign ifb.core_res      = ifa.core_res;
   assign ifb.core_move     = ifa.core_move;
   assign ifb.res_ready     = ifa.res_ready;

   search_slot_scheduler #(.NCTX(8), .TASK_DEPTH(16), .RES_DEPTH(16)) u_dut_a (
      .iCLOCK (clk),
      .iRESET (rst),
      .bus    (ifa)
   );

   search_slot_scheduler #(.NCTX(8), .TASK_DEPTH(16), .RES_DEPTH(2)) u_dut_b (
      .iCLOCK (clk),
      .iRESET (rst),
      .bus    (ifb)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic core(input int slot, input logic free, input logic solved, input int res, input logic move);
      ifa.core_slot   = 3'(slot);
      ifa.core_free   = free;
      ifa.core_solved = solved;
      ifa.core_res    = 8'(res);
      ifa.core_move   = move;
   endtask

   task automatic push_task(input int id);
      ifa.task_valid    = 1'b1;
      ifa.task_id       = 16'(id);
      ifa.task_player   = 64'h1000 + 64'(id);
      ifa.task_opponent = 64'h2000 + 64'(id);
      ifa.task_alpha    = SCORE_MIN;
      ifa.task_beta     = SCORE_MAX;
      tick();
      ifa.task_valid    = 1'b0;
   endtask

   initial begin
      rst               = 1'b1;
      ifa.task_valid    = 1'b0;
      ifa.task_player   = '0;
      ifa.task_opponent = '0;
      ifa.task_id       = '0;
      ifa.task_alpha    = '0;
      ifa.task_beta     = '0;
      ifa.node_budget   = '0;
      ifa.res_ready     = 1'b0;
      core(0, 1'b1, 1'b0, 0, 1'b0);
      tick();
      tick();
      settle();
      chk("rst_task_ready", ifa.task_ready, 0);
      chk("rst_inj_valid", ifa.inj_valid, 0);
      chk("rst_res_valid", ifa.res_valid, 0);
      chk("rst_busy", ifa.busy_slots, 0);
      chk("rst_err", ifa.err_spurious, 0);
      rst = 1'b0;
      core(7, 1'b0, 1'b0, 0, 1'b0);
      settle();
      chk("post_rst_task_ready", ifa.task_ready, 1);
      tick();

      // Three tasks, then three free slots.
      for (int k = 1; k <= 3; k++) push_task(k);
      for (int s = 0; s < 3; s++) begin
         core(s, 1'b1, 1'b0, 0, 1'b0);
         settle();
         chk("inj_valid", ifa.inj_valid, 1);
         chk("inj_taskid", ifa.inj_taskid, 64'(s + 1));
         chk("inj_player", ifa.inj_player, 64'h1001 + 64'(s));
         chk("inj_alpha", ifa.inj_alpha, SCORE_MIN);
         chk("inj_beta", ifa.inj_beta, SCORE_MAX);
         tick();
      end
      core(3, 1'b1, 1'b0, 0, 1'b0);
      settle();
      chk("inj_valid_empty", ifa.inj_valid, 0);
      chk("inj_player_zero", ifa.inj_player, 0);
      chk("busy_after_inj", ifa.busy_slots, 8'b0000_0111);
      tick();

      // Slot 1: five moves, then solved with +12.
      for (int m = 0; m < 5; m++) begin
         core(1, 1'b0, 1'b0, 0, 1'b1);
         tick();
      end
      core(1, 1'b1, 1'b1, 12, 1'b0);
      settle();
      chk("res_valid_same_cycle", ifa.res_valid, 0);
      tick();
      core(7, 1'b0, 1'b0, 0, 1'b0);
      settle();
      chk("res_valid", ifa.res_valid, 1);
      chk("res_id", ifa.res_id, 2);
      chk("res_score", ifa.res_score, 12);
      chk("res_nodes", ifa.res_nodes, 5);
      chk("res_aborted", ifa.res_aborted, 0);
      chk("busy_after_solve", ifa.busy_slots, 8'b0000_0101);
      ifa.res_ready = 1'b1;
      tick();
      ifa.res_ready = 1'b0;
      settle();
      chk("res_valid_popped", ifa.res_valid, 0);
      chk("res_id_zero", ifa.res_id, 0);

      // Budget of 4 on slot 0.
      ifa.node_budget = 32'd4;
      core(0, 1'b0, 1'b0, 0, 1'b0);
      settle();
      chk("abort_before_moves", ifa.abort, 0);
      tick();
      for (int m = 0; m < 4; m++) begin
         core(0, 1'b0, 1'b0, 0, 1'b1);
         settle();
         chk("abort_during_moves", ifa.abort, 0);
         tick();
      end
      core(2, 1'b0, 1'b0, 0, 1'b0);
      settle();
      chk("abort_other_slot", ifa.abort, 0);
      tick();
      core(0, 1'b0, 1'b0, 0, 1'b0);
      settle();
      chk("abort_next_visit", ifa.abort, 1);
      tick();
      core(0, 1'b1, 1'b1, -8, 1'b0);
      settle();
      chk("abort_on_solve", ifa.abort, 1);
      tick();
      core(0, 1'b0, 1'b0, 0, 1'b0);
      settle();
      chk("abort_after_solve", ifa.abort, 0);
      chk("ab_res_valid", ifa.res_valid, 1);
      chk("ab_res_id", ifa.res_id, 1);
      chk("ab_res_score", ifa.res_score, -8);
      chk("ab_res_nodes", ifa.res_nodes, 4);
      chk("ab_res_aborted", ifa.res_aborted, 1);
      ifa.res_ready = 1'b1;
      tick();
      ifa.res_ready   = 1'b0;
      ifa.node_budget = '0;

      // Solve reported on idle slot 5.
      core(5, 1'b0, 1'b1, 7, 1'b0);
      settle();
      chk("err_not_yet", ifa.err_spurious, 0);
      tick();
      core(7, 1'b0, 1'b0, 0, 1'b0);
      settle();
      chk("spurious_no_result", ifa.res_valid, 0);
      chk("err_set", ifa.err_spurious, 1);
      tick();
      tick();
      tick();
      chk("err_sticky", ifa.err_spurious, 1);

      // Fill the task FIFO while no slot is free, then reset with slot 2 still busy.
      for (int k = 0; k < 16; k++) begin
         if (k == 15) begin
            settle();
            chk("task_ready_one_left", ifa.task_ready, 1);
         end
         push_task(100 + k);
      end
      settle();
      chk("task_ready_full", ifa.task_ready, 0);
      chk("busy_before_reset", ifa.busy_slots, 8'b0000_0100);
      rst = 1'b1;
      core(0, 1'b1, 1'b0, 0, 1'b0);
      settle();
      chk("inj_valid_in_reset", ifa.inj_valid, 0);
      tick();
      rst = 1'b0;
      core(7, 1'b0, 1'b0, 0, 1'b0);
      settle();
      chk("mid_rst_busy", ifa.busy_slots, 0);
      chk("mid_rst_res_valid", ifa.res_valid, 0);
      chk("mid_rst_task_ready", ifa.task_ready, 1);
      chk("mid_rst_err", ifa.err_spurious, 0);
      core(0, 1'b1, 1'b0, 0, 1'b0);
      settle();
      chk("mid_rst_fifo_flushed", ifa.inj_valid, 0);
      tick();

      // Credit limit on the RES_DEPTH=2 instance.
      core(7, 1'b0, 1'b0, 0, 1'b0);
      for (int k = 11; k <= 14; k++) push_task(k);
      for (int s = 0; s < 4; s++) begin
         core(s, 1'b1, 1'b0, 0, 1'b0);
         settle();
         chk("b_inj_valid", ifb.inj_valid, (s < 2) ? 64'd1 : 64'd0);
         chk("b_inj_taskid", ifb.inj_taskid, (s < 2) ? 64'(11 + s) : 64'd0);
         tick();
      end
      core(0, 1'b1, 1'b1, 3, 1'b0);
      settle();
      chk("b_inj_blocked_solve", ifb.inj_valid, 0);
      tick();
      core(1, 1'b1, 1'b1, 5, 1'b0);
      settle();
      chk("b_res_valid", ifb.res_valid, 1);
      chk("b_res_id_first", ifb.res_id, 11);
      tick();
      core(2, 1'b1, 1'b0, 0, 1'b0);
      ifa.res_ready = 1'b1;
      settle();
      chk("b_inj_blocked_full", ifb.inj_valid, 0);
      chk("b_res_score_first", ifb.res_score, 3);
      tick();
      ifa.res_ready = 1'b0;
      settle();
      chk("b_inj_after_pop", ifb.inj_valid, 1);
      chk("b_inj_taskid_after_pop", ifb.inj_taskid, 13);
      chk("b_res_id_second", ifb.res_id, 12);
      chk("b_res_score_second", ifb.res_score, 5);
      tick();
      core(3, 1'b1, 1'b0, 0, 1'b0);
      settle();
      chk("b_inj_blocked_again", ifb.inj_valid, 0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
